// File: rtl/mp_adder_seq.sv
// mp_adder_seq: multi-cycle, multi-precision adder/subtractor.
// One SEG_WIDTH-bit segment adder is reused across WIDTH/SEG_WIDTH cycles,
// least-significant segment first, with the carry registered between
// segments. This keeps the carry chain short enough for the core clock.

// Single segment adder: {cout, sum} = a + b + cin.
module adder_segment #(
  parameter int SEG_WIDTH = 32
) (
  input  logic [SEG_WIDTH-1:0] i_a,
  input  logic [SEG_WIDTH-1:0] i_b,
  input  logic                 i_cin,
  output logic [SEG_WIDTH-1:0] o_sum,
  output logic                 o_cout
);
  logic [SEG_WIDTH:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SEG_WIDTH{1'b0}}, i_cin};
  assign o_sum   = w_total[SEG_WIDTH-1:0];
  assign o_cout  = w_total[SEG_WIDTH];
endmodule

module mp_adder_seq #(
  parameter int WIDTH     = 1024,
  parameter int SEG_WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [SEG_WIDTH-1:0] w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_result_next;
  logic                 w_last_seg;

  adder_segment #(
    .SEG_WIDTH (SEG_WIDTH)
  ) u_seg (
    .i_a    (r_a[SEG_WIDTH-1:0]),
    .i_b    (r_b[SEG_WIDTH-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // New sum segment enters at the MSB end; after NSEG shifts the segments
  // sit in natural order. A single-segment configuration has nothing to shift.
  generate
    if (NSEG > 1) begin : g_shift
      assign w_result_next = {w_sum, r_result[WIDTH-1:SEG_WIDTH]};
    end else begin : g_noshift
      assign w_result_next = w_sum;
    end
  endgenerate

  assign w_last_seg = (r_cnt == CW'(NSEG - 1));

  // Control FSM and segment datapath; all outputs come straight from registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in
            // on the initial carry.
            r_a     <= in_a;
            r_b     <= subtract ? ~in_b : in_b;
            r_carry <= subtract;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          r_a      <= r_a >> SEG_WIDTH;
          r_b      <= r_b >> SEG_WIDTH;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last_seg) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Start is deliberately ignored here; the next one is taken in IDLE.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry;
endmodule
